ysyx_24110015_scoreboard: RTL and testbench

Register-hazard scoreboard and issue gate between IDU and EXU of the ysyx_24110015 multi-cycle core. Counts in-flight GPR writes per architectural register and in-flight CSR-touching instructions, and holds the IDU→EXU handshake while a source register or the CSR file has a pending write. Retirement is taken from the WBU output handshake (WBU `out_valid`/`out_ready`), so the WBU stays a pure datapath stage and this block does all hazard sequencing.

---
 rtl/ysyx_24110015_scoreboard.sv | 128 ++++++++++++
 tb/tb_ysyx_24110015_scoreboard.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110015_scoreboard.sv
// GPR/CSR hazard scoreboard gating IDU->EXU; combinational stalls, counters update 1 cycle after fire, no buffering.
// Define YSYX_24110015_SB_WAW_STALL_EN to allow only one outstanding write per register (WAW serialized).
module ysyx_24110015_scoreboard #(
    parameter int NREG  = 16,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_rs1_use,
    input  logic            id_rs2_use,
    input  logic [4:0]      id_rd,
    input  logic            id_RegWrite,
    input  logic            id_csr,
    output logic            ex_valid,
    input  logic            ex_ready,
    input  logic            wb_valid,
    input  logic            wb_ready,
    input  logic            wb_RegWrite,
    input  logic [4:0]      wb_addr,
    input  logic            wb_csr,
    output logic            stall_raw,
    output logic            stall_csr,
    output logic [NREG-1:0] pending,
    output logic            sb_err
);
    localparam int IW = $clog2(NREG);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [CNT_W-1:0] csr_cnt_q, csr_cnt_d;
    logic             sb_err_q, sb_err_d;

    logic [IW-1:0] rs1_idx, rs2_idx, rd_idx, wb_idx;
    logic          stall_cap, stall, issue_fire, retire_fire;
    logic          gpr_inc, gpr_dec, csr_inc, csr_dec;

    // Out-of-range indices alias onto the low bits.
    assign rs1_idx = id_rs1[IW-1:0];
    assign rs2_idx = id_rs2[IW-1:0];
    assign rd_idx  = id_rd[IW-1:0];
    assign wb_idx  = wb_addr[IW-1:0];

    generate
        if (IW < 5) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^{id_rs1[4:IW], id_rs2[4:IW], id_rd[4:IW], wb_addr[4:IW]};
        end
    endgenerate

    always_comb begin
        pending = '0;
        for (int i = 1; i < NREG; i++) begin
            pending[i] = |cnt_q[i];
        end
    end

    always_comb begin
        stall_raw = (id_rs1_use && (rs1_idx != '0) && (cnt_q[rs1_idx] != '0)) ||
                    (id_rs2_use && (rs2_idx != '0) && (cnt_q[rs2_idx] != '0));
        stall_csr = id_csr && ((csr_cnt_q != '0) || (|pending));
`ifdef YSYX_24110015_SB_WAW_STALL_EN
        stall_cap = (id_RegWrite && (rd_idx != '0) && (cnt_q[rd_idx] != '0)) ||
                    (id_csr && (csr_cnt_q == CNT_MAX));
`else
        stall_cap = (id_RegWrite && (rd_idx != '0) && (cnt_q[rd_idx] == CNT_MAX)) ||
                    (id_csr && (csr_cnt_q == CNT_MAX));
`endif
        stall       = stall_raw || stall_csr || stall_cap;
        ex_valid    = id_valid && !stall;
        id_ready    = ex_ready && !stall;
        issue_fire  = id_valid && ex_ready && !stall;
        retire_fire = wb_valid && wb_ready;
        gpr_inc     = issue_fire && id_RegWrite && (rd_idx != '0);
        gpr_dec     = retire_fire && wb_RegWrite && (wb_idx != '0);
        csr_inc     = issue_fire && id_csr;
        csr_dec     = retire_fire && wb_csr;
    end

    // Simultaneous inc/dec on one counter cancels; decrementing zero flags an error instead.
    always_comb begin
        sb_err_d  = sb_err_q;
        csr_cnt_d = csr_cnt_q;
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (gpr_inc && (rd_idx == IW'(i)) && !(gpr_dec && (wb_idx == IW'(i)))) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (gpr_dec && (wb_idx == IW'(i)) && !(gpr_inc && (rd_idx == IW'(i)))) begin
                if (cnt_q[i] == '0) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
        if (csr_inc && !csr_dec) begin
            csr_cnt_d = csr_cnt_q + CNT_W'(1);
        end else if (csr_dec && !csr_inc) begin
            if (csr_cnt_q == '0) begin
                sb_err_d = 1'b1;
            end else begin
                csr_cnt_d = csr_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            csr_cnt_q <= '0;
            sb_err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            csr_cnt_q <= csr_cnt_d;
            sb_err_q  <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;
endmodule

// File: tb/tb_ysyx_24110015_scoreboard.sv
// Directed bench for the scoreboard: one vector per cycle, outputs checked mid-cycle before the edge.
module tb_ysyx_24110015_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready, id_rs1_use, id_rs2_use, id_RegWrite, id_csr;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_addr;
    logic        ex_valid, ex_ready, wb_valid, wb_ready, wb_RegWrite, wb_csr;
    logic        stall_raw, stall_csr, sb_err;
    logic [15:0] pending;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_24110015_scoreboard #(.NREG(16), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
        .id_rd(id_rd), .id_RegWrite(id_RegWrite), .id_csr(id_csr),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_RegWrite(wb_RegWrite), .wb_addr(wb_addr), .wb_csr(wb_csr),
        .stall_raw(stall_raw), .stall_csr(stall_csr),
        .pending(pending), .sb_err(sb_err)
    );

    typedef struct {
        logic        idv, exr;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        rw, csr, wbv, wbr, wrw;
        logic [4:0]  wa;
        logic        wc;
        logic        e_exv, e_idr, e_raw, e_csr;
        logic [15:0] e_pend;
        logic        e_err;
    } vec_t;

    vec_t vt [38];

    // Issue-side fields, retire-side fields, expected {ex_valid, id_ready, stall_raw, stall_csr, pending, sb_err}.
    function automatic vec_t mk(
        input logic idv, input logic exr, input logic [4:0] rs1, input logic u1,
        input logic [4:0] rs2, input logic u2, input logic [4:0] rd, input logic rw,
        input logic csr, input logic wbv, input logic wbr, input logic wrw,
        input logic [4:0] wa, input logic wc,
        input logic e_exv, input logic e_idr, input logic e_raw, input logic e_csr,
        input logic [15:0] e_pend, input logic e_err);
        vec_t v;
        v.idv = idv; v.exr = exr; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rd = rd; v.rw = rw; v.csr = csr; v.wbv = wbv; v.wbr = wbr; v.wrw = wrw;
        v.wa = wa; v.wc = wc; v.e_exv = e_exv; v.e_idr = e_idr; v.e_raw = e_raw;
        v.e_csr = e_csr; v.e_pend = e_pend; v.e_err = e_err;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_valid = v.idv; ex_ready = v.exr; id_rs1 = v.rs1; id_rs1_use = v.u1;
        id_rs2 = v.rs2; id_rs2_use = v.u2; id_rd = v.rd; id_RegWrite = v.rw;
        id_csr = v.csr; wb_valid = v.wbv; wb_ready = v.wbr; wb_RegWrite = v.wrw;
        wb_addr = v.wa; wb_csr = v.wc;
    endtask

    task automatic check(input string name, input vec_t v);
        logic [20:0] act, exp;
        act = {ex_valid, id_ready, stall_raw, stall_csr, pending, sb_err};
        exp = {v.e_exv, v.e_idr, v.e_raw, v.e_csr, v.e_pend, v.e_err};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {exv,idr,raw,csr,pend,err}=%b_%b_%b_%b_%h_%b want %b_%b_%b_%b_%h_%b",
                     name, act[20], act[19], act[18], act[17], act[16:1], act[0],
                     exp[20], exp[19], exp[18], exp[17], exp[16:1], exp[0]);
        end
    endtask

    initial begin
        //            idv exr rs1 u1 rs2 u2 rd  rw csr wbv wbr wrw wa  wc  exv idr raw csr pend     err
        vt[0]  = mk(1, 1, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 16'h0000, 0); // addi x5
        vt[1]  = mk(1, 1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 16'h0020, 0); // add x6,x5,x0
        vt[2]  = mk(1, 1, 5, 1, 0, 1, 6, 1, 0, 1, 1, 1, 5, 0,  0, 0, 1, 0, 16'h0020, 0); // retire x5, still held
        vt[3]  = mk(1, 1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 16'h0000, 0);
        vt[4]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 6, 0,  0, 1, 0, 0, 16'h0040, 0);
        vt[5]  = mk(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 16'h0000, 0); // x7 write #1
        vt[6]  = mk(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 16'h0080, 0);
        vt[7]  = mk(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 16'h0080, 0);
        vt[8]  = mk(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 16'h0080, 0); // cap
        vt[9]  = mk(1, 1, 0, 0, 0, 0, 7, 1, 0, 1, 1, 1, 7, 0,  0, 0, 0, 0, 16'h0080, 0);
        vt[10] = mk(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 16'h0080, 0); // resumes
        vt[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7, 0,  0, 1, 0, 0, 16'h0080, 0);
        vt[12] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7, 0,  0, 1, 0, 0, 16'h0080, 0);
        vt[13] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7, 0,  0, 1, 0, 0, 16'h0080, 0);
        vt[14] = mk(1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 16'h0000, 0); // x9
        vt[15] = mk(1, 1, 0, 0, 0, 0, 9, 1, 0, 1, 1, 1, 9, 0,  1, 1, 0, 0, 16'h0200, 0); // issue+retire x9
        vt[16] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 16'h0200, 0);
        vt[17] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 9, 0,  0, 1, 0, 0, 16'h0200, 0);
        vt[18] = mk(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 16'h0000, 0); // addi x3
        vt[19] = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 16'h0008, 0); // csrrw
        vt[20] = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 3, 0,  0, 0, 0, 1, 16'h0008, 0);
        vt[21] = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 16'h0000, 0);
        vt[22] = mk(1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 16'h0000, 0); // addi x4
        vt[23] = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 16'h0010, 0); // csrrs
        vt[24] = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 4, 0,  0, 0, 0, 1, 16'h0010, 0);
        vt[25] = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 16'h0000, 0); // csr_cnt=1
        vt[26] = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1,  0, 0, 0, 1, 16'h0000, 0); // wb_csr
        vt[27] = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 16'h0000, 0);
        vt[28] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1,  0, 1, 0, 0, 16'h0000, 0);
        vt[29] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0,  0, 1, 0, 0, 16'h0000, 0); // x0 retire
        vt[30] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 12, 0, 0, 1, 0, 0, 16'h0000, 0); // no ready
        vt[31] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 12, 0, 0, 1, 0, 0, 16'h0000, 0); // underflow
        vt[32] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 16'h0000, 1);
        vt[33] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 16'h0000, 1);
        vt[34] = mk(1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0000, 1); // ex_ready low
        vt[35] = mk(1, 1, 0, 0, 0, 0, 16, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0000, 1); // rd=16 aliases x0
        vt[36] = mk(1, 1, 5, 1, 16, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0000, 1);
        vt[37] = mk(1, 1, 0, 0, 0, 0, 21, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0000, 1); // rd=21 -> x5

        rst = 1'b0;
        drive(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0));
        #12;
        check("reset", mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0000, 0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 38; i++) begin
            drive(vt[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), vt[i]);
            @(posedge clk);
            #1;
        end

        // rd=21 issued above, so x5 is now pending; a reader of x5 stalls.
        drive(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0));
        @(negedge clk);
        check("alias_raw", mk(0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0020, 1));

        // Asynchronous reset mid-cycle clears counters and the sticky error at once.
        #2;
        rst = 1'b0;
        #1;
        check("async_rst", mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0000, 0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0));
        @(negedge clk);
        check("post_rst", mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
